// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage
// and a line-wide data memory with an enable/ack handshake.
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int LINE_W    = 256,
    parameter int TAG_W     = 22
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_REFILL_DONE
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word_sel;
    logic              req;
    logic              hit;
    logic              write_hit;
    logic              read_hit;
    logic              refill_done;
    logic [LINE_W-1:0] line_rd;
    logic [LINE_W-1:0] line_wr;
    logic [31:0]       line_words [WORDS];
    logic              unused_addr_bits;

    assign req_tag          = p1_addr_i[31 -: TAG_W];
    assign idx              = p1_addr_i[OFF_W +: IDX_W];
    assign word_sel         = p1_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    assign req  = p1_MemRead_i | p1_MemWrite_i;
    assign hit  = valid_q[idx] & (tag_q[idx] == req_tag);

    // Asserting both read and write is treated as a store.
    assign write_hit   = (state_q == S_IDLE) & p1_MemWrite_i & hit;
    assign read_hit    = (state_q == S_IDLE) & p1_MemRead_i & ~p1_MemWrite_i & hit;
    assign refill_done = (state_q == S_REFILL_DONE);

    assign p1_stall_o = req & ~((state_q == S_IDLE) & hit);

    assign line_rd = data_q[idx];

    // Word view of the selected line, and the same line with the store word merged in.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi]       = line_rd[gi*32 +: 32];
            assign line_wr[gi*32 +: 32] = (word_sel == WSEL_W'(gi)) ? p1_data_i
                                                                    : line_rd[gi*32 +: 32];
        end
    endgenerate

    assign p1_data_o = read_hit ? line_words[word_sel] : 32'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_ack_i) begin
                    state_d = S_REFILL_DONE;
                end
            end
            S_REFILL_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = '0;
        case (state_q)
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx], idx, {OFF_W{1'b0}}};
                mem_data_o   = line_rd;
            end
            S_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, {OFF_W{1'b0}}};
            end
            default: begin
                mem_enable_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (refill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (write_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (refill_done) begin
                tag_q[idx]  <= req_tag;
                data_q[idx] <= mem_data_i;
            end else if (write_hit) begin
                data_q[idx] <= line_wr;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed CPU accesses against a
// fixed-latency line memory model; expected CPU and memory transactions are queued.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack;
    logic [255:0] mem_rdata;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p1_MemRead_i  (rd),
        .p1_MemWrite_i (wr),
        .p1_addr_i     (addr),
        .p1_data_i     (wdata),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_ack_i     (mem_ack),
        .mem_data_i    (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          stalls;
    } cpu_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic        chk;
        int          widx;
        logic [31:0] word;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // Unwritten memory content: each word holds its own byte address XOR 0xC0DE0000.
    function automatic logic [255:0] pattern(input logic [31:0] line_addr);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = (line_addr + 32'(w * 4)) ^ 32'hC0DE0000;
        end
        return l;
    endfunction

    logic [255:0] wb_arr [256];
    logic         wb_vld [256];
    int           lat_cnt;
    logic [31:0]  lat_addr;
    logic         lat_wr;

    // Memory: ack 10 cycles after enable is first sampled, refill data the cycle after ack.
    always @(posedge clk) begin
        if (rst) begin
            mem_ack   <= 1'b0;
            lat_cnt   <= 0;
            lat_addr  <= 32'd0;
            lat_wr    <= 1'b0;
            mem_rdata <= '0;
            for (int i = 0; i < 256; i++) begin
                wb_vld[i] <= 1'b0;
            end
        end else begin
            mem_ack <= 1'b0;
            if (mem_ack) begin
                lat_cnt <= 0;
                if (!lat_wr) begin
                    mem_rdata <= wb_vld[lat_addr[12:5]] ? wb_arr[lat_addr[12:5]] : pattern(lat_addr);
                end
            end else if (mem_enable_o) begin
                if (lat_cnt == 9) begin
                    mem_ack  <= 1'b1;
                    lat_cnt  <= 0;
                    lat_addr <= mem_addr_o;
                    lat_wr   <= mem_write_o;
                    if (mem_write_o) begin
                        wb_arr[mem_addr_o[12:5]] <= mem_data_o;
                        wb_vld[mem_addr_o[12:5]] <= 1'b1;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end else begin
                lat_cnt <= 0;
            end
        end
    end

    // Monitor: samples on the falling edge, pops expectations as the DUT completes them.
    initial begin
        int       stall_cnt;
        cpu_exp_t ce;
        mem_exp_t me;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
            end else begin
                if (mem_ack && mem_enable_o) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: got wr=%0b addr=%08h, required no request",
                                 mem_write_o, mem_addr_o);
                    end else begin
                        me = mem_q.pop_front();
                        $display("mem  wr=%0b addr=%08h", mem_write_o, mem_addr_o);
                        checks++;
                        if (mem_write_o !== me.wr) begin
                            errors++;
                            $display("FAIL mem_write: got %0b required %0b", mem_write_o, me.wr);
                        end
                        checks++;
                        if (mem_addr_o !== me.addr) begin
                            errors++;
                            $display("FAIL mem_addr: got %08h required %08h", mem_addr_o, me.addr);
                        end
                        if (me.chk) begin
                            checks++;
                            if (mem_data_o[me.widx*32 +: 32] !== me.word) begin
                                errors++;
                                $display("FAIL mem_wb_word%0d: got %08h required %08h", me.widx,
                                         mem_data_o[me.widx*32 +: 32], me.word);
                            end
                        end
                    end
                end
                if (rd || wr) begin
                    if (p1_stall_o) begin
                        stall_cnt++;
                    end else begin
                        checks++;
                        if (cpu_q.size() == 0) begin
                            errors++;
                            $display("FAIL cpu_unexpected: completion at addr %08h with no expectation", addr);
                        end else begin
                            ce = cpu_q.pop_front();
                            $display("cpu  rd=%0b wr=%0b addr=%08h data_o=%08h stalls=%0d",
                                     rd, wr, addr, p1_data_o, stall_cnt);
                            if (p1_data_o !== ce.data) begin
                                errors++;
                                $display("FAIL cpu_data@%08h: got %08h required %08h",
                                         ce.addr, p1_data_o, ce.data);
                            end
                            checks++;
                            if (stall_cnt != ce.stalls) begin
                                errors++;
                                $display("FAIL cpu_stalls@%08h: got %0d required %0d",
                                         ce.addr, stall_cnt, ce.stalls);
                            end
                        end
                        stall_cnt = 0;
                    end
                end else begin
                    stall_cnt = 0;
                    checks++;
                    if (p1_stall_o !== 1'b0 || mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 ||
                        mem_addr_o !== 32'd0 || p1_data_o !== 32'd0) begin
                        errors++;
                        $display("FAIL idle_outputs: got stall=%0b en=%0b wr=%0b addr=%08h data=%08h, required all 0",
                                 p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, p1_data_o);
                    end
                end
            end
            if (done) begin
                checks++;
                if (cpu_q.size() != 0 || mem_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: got cpu=%0d mem=%0d pending, required 0 and 0",
                             cpu_q.size(), mem_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic exp_mem(input logic w, input logic [31:0] a, input logic chk,
                           input int widx, input logic [31:0] word);
        mem_q.push_back('{wr: w, addr: a, chk: chk, widx: widx, word: word});
    endtask

    task automatic cpu_op(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_data, input int exp_stalls);
        bit released;
        cpu_q.push_back('{addr: a, data: exp_data, stalls: exp_stalls});
        rd       = r;
        wr       = w;
        addr     = a;
        wdata    = d;
        released = 1'b0;
        for (int n = 0; n < 200 && !released; n++) begin
            @(negedge clk);
            if (!p1_stall_o) released = 1'b1;
        end
        if (!released) begin
            $display("FAIL stall_timeout@%08h: stall still 1 after 200 cycles, required release", a);
            $fatal(1, "stall bound expired");
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold read miss: one refill, 13 stall cycles.
        exp_mem(1'b0, 32'h0000_0400, 1'b0, 0, 32'd0);
        cpu_op(1'b1, 1'b0, 32'h0000_0400, 32'd0, 32'hC0DE_0400, 13);

        // Store hit then load hit.
        cpu_op(1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 32'd0, 0);
        cpu_op(1'b1, 1'b0, 32'h0000_0404, 32'd0, 32'hDEAD_BEEF, 0);

        // Dirty eviction: write-back then refill, 24 stall cycles.
        exp_mem(1'b1, 32'h0000_0400, 1'b1, 1, 32'hDEAD_BEEF);
        exp_mem(1'b0, 32'h0000_0000, 1'b0, 0, 32'd0);
        cpu_op(1'b1, 1'b0, 32'h0000_0004, 32'd0, 32'hC0DE_0004, 24);

        // Clean eviction: refill only.
        exp_mem(1'b0, 32'h0000_0800, 1'b0, 0, 32'd0);
        cpu_op(1'b1, 1'b0, 32'h0000_0800, 32'd0, 32'hC0DE_0800, 13);

        // Store miss allocates, then hits on the merged and untouched words.
        exp_mem(1'b0, 32'h0000_0C00, 1'b0, 0, 32'd0);
        cpu_op(1'b0, 1'b1, 32'h0000_0C08, 32'h1234_5678, 32'd0, 13);
        cpu_op(1'b1, 1'b0, 32'h0000_0C08, 32'd0, 32'h1234_5678, 0);
        cpu_op(1'b1, 1'b0, 32'h0000_0C0F, 32'd0, 32'hC0DE_0C0C, 0);
        cpu_op(1'b1, 1'b0, 32'h0000_0C1C, 32'd0, 32'hC0DE_0C1C, 0);

        // Evict the stored line; refetch the earlier written-back line.
        exp_mem(1'b1, 32'h0000_0C00, 1'b1, 2, 32'h1234_5678);
        exp_mem(1'b0, 32'h0000_0400, 1'b0, 0, 32'd0);
        cpu_op(1'b1, 1'b0, 32'h0000_0404, 32'd0, 32'hDEAD_BEEF, 24);

        // Last index; read+write together behaves as a store.
        exp_mem(1'b0, 32'h0000_03E0, 1'b0, 0, 32'd0);
        cpu_op(1'b1, 1'b0, 32'h0000_03FC, 32'd0, 32'hC0DE_03FC, 13);
        cpu_op(1'b1, 1'b1, 32'h0000_03F0, 32'hA5A5_A5A5, 32'd0, 0);
        cpu_op(1'b1, 1'b0, 32'h0000_03F0, 32'd0, 32'hA5A5_A5A5, 0);

        // Reset in the middle of a refill.
        rd   = 1'b1;
        addr = 32'h0000_05E0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        rd  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_mem(1'b0, 32'h0000_05E0, 1'b0, 0, 32'd0);
        cpu_op(1'b1, 1'b0, 32'h0000_05E0, 32'd0, 32'hC0DE_05E0, 13);
        exp_mem(1'b0, 32'h0000_03E0, 1'b0, 0, 32'd0);
        cpu_op(1'b1, 1'b0, 32'h0000_03F0, 32'd0, 32'hC0DE_03F0, 13);

        // Long idle stretch.
        repeat (50) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
